// File: rtl/uart_tx_stream.sv
// uart_tx_stream: UART transmitter fed by a valid/ready word stream.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT clocks.
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, a parity bit
// is sent after the data (even parity, or odd parity when PARITY_ODD = 1).
// tx, tx_busy and tx_done come straight from flops, so tx cannot glitch.
module uart_tx_stream #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk_50M,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;      // clocks elapsed in the current bit
    logic [BW-1:0]          bit_q, bit_d;      // data bit index, reused as stop bit index
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;  // word still to be shifted out
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   bit_end;

`ifdef UART_TX_PARITY_EN
    // Parity is taken from a copy of the accepted word, because the shift
    // register has already been emptied by the time the parity bit is due.
    logic [DATA_BITS-1:0]   word_q, word_d;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] w);
        return (^w) ^ (PARITY_ODD != 0);
    endfunction
`else
    // PARITY_ODD has no effect without the parity feature.
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    assign tx_ready = (state_q == IDLE) && !rst;
    assign bit_end  = (cnt_q == CNT_LAST);

    // Next-state logic: bit timing, frame sequencing and line value
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        word_d  = word_q;
`endif
        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    shreg_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    word_d  = tx_data;
`endif
                    state_d = START;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_bit(word_q);
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Control state register; reset idles the line and drops any frame in flight
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Data registers; they are only read after a handshake has loaded them
    always_ff @(posedge clk_50M) begin
        shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
        word_q  <= word_d;
`endif
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: two instances (one and two stop bits) sharing
// clock and reset. The stimulus pushes expected words into per-instance
// queues; a negedge monitor watches each tx line, pops an entry when a
// start bit appears, and checks every sample of the frame and the tx_done
// cycle that follows it.
module tb_uart_tx_stream;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int CPB = 4;
    localparam int FL0 = 40 + 4 * PB;   // 8N1 frame, plus 4 clocks of parity
    localparam int FL1 = 44 + 4 * PB;   // 8N2 frame, plus 4 clocks of parity

    typedef struct packed {
        logic [7:0] w;
        logic       par;
    } exp_t;

    logic       clk_50M = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] tx_data_w  [2];
    logic       tx_valid_w [2];
    logic       tx_ready_w [2];
    logic       tx_w       [2];
    logic       tx_busy_w  [2];
    logic       tx_done_w  [2];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    exp_t exp_q0 [$];
    exp_t exp_q1 [$];

    int         s_a      [2];
    bit         in_fr    [2];
    bit         exp_dn   [2];
    bit         skip     [2];
    logic [11:0] fbits   [2];
    int         nsamp    [2];
    int         ferr     [2];
    logic [7:0] cur_w    [2];
    int         done_cnt [2];
    int         done_cyc [2];
    int         done_prev[2];
    int         spur = 0;

    always #5 clk_50M = ~clk_50M;
    always @(posedge clk_50M) cyc <= cyc + 1;

    uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
        .clk_50M (clk_50M),
        .rst     (rst),
        .tx_data (tx_data_w[0]),
        .tx_valid(tx_valid_w[0]),
        .tx_ready(tx_ready_w[0]),
        .tx      (tx_w[0]),
        .tx_busy (tx_busy_w[0]),
        .tx_done (tx_done_w[0])
    );

    uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) u_dut1 (
        .clk_50M (clk_50M),
        .rst     (rst),
        .tx_data (tx_data_w[1]),
        .tx_valid(tx_valid_w[1]),
        .tx_ready(tx_ready_w[1]),
        .tx      (tx_w[1]),
        .tx_busy (tx_busy_w[1]),
        .tx_done (tx_done_w[1])
    );

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input int g, input logic [7:0] w, input logic p);
        exp_t e;
        e.w   = w;
        e.par = p;
        if (g == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic send(input int g, input logic [7:0] w, input logic p, output int hs);
        int n;
        push(g, w, p);
        @(posedge clk_50M);
        #1;
        tx_data_w[g]  = w;
        tx_valid_w[g] = 1'b1;
        n = 0;
        @(negedge clk_50M);
        while (!tx_ready_w[g] && n < 500) begin
            @(negedge clk_50M);
            n++;
        end
        check_eq($sformatf("send_ready%0d", g), int'(tx_ready_w[g]), 1);
        @(posedge clk_50M);
        #1;
        tx_valid_w[g] = 1'b0;
        hs = cyc;
        @(negedge clk_50M);
        check_eq($sformatf("start_bit%0d", g), int'({tx_w[g], tx_busy_w[g]}), 1);
    endtask

    task automatic wait_done(input int g, input int target);
        int n;
        n = 0;
        while (done_cnt[g] < target && n < 400) begin
            @(negedge clk_50M);
            n++;
        end
        check_eq($sformatf("done_count%0d", g), done_cnt[g], target);
    endtask

    // Monitor: rebuild each expected frame and compare it sample by sample
    initial begin : monitor
        exp_t        e;
        logic [11:0] fb;
        int          sz;
        for (int g = 0; g < 2; g++) begin
            s_a[g] = 0; in_fr[g] = 1'b0; exp_dn[g] = 1'b0; skip[g] = 1'b0;
            nsamp[g] = 0; ferr[g] = 0; cur_w[g] = '0; fbits[g] = '1;
            done_cnt[g] = 0; done_cyc[g] = 0; done_prev[g] = 0;
        end
        forever begin
            @(negedge clk_50M);
            for (int g = 0; g < 2; g++) begin
                if (rst) begin
                    in_fr[g]  = 1'b0;
                    exp_dn[g] = 1'b0;
                    skip[g]   = 1'b0;
                    if (tx_done_w[g] !== 1'b0) spur++;
                end else if (exp_dn[g]) begin
                    check_eq($sformatf("done_cycle%0d", g),
                             int'({tx_done_w[g], tx_w[g], tx_busy_w[g]}), 3'b110);
                    check_eq($sformatf("frame%0d_word%02h_bad_samples", g, cur_w[g]), ferr[g], 0);
                    done_prev[g] = done_cyc[g];
                    done_cyc[g]  = cyc;
                    done_cnt[g]++;
                    exp_dn[g] = 1'b0;
                end else begin
                    if (skip[g] && tx_w[g] === 1'b1) skip[g] = 1'b0;
                    if (!in_fr[g] && !skip[g] && tx_w[g] === 1'b0) begin
                        sz = (g == 0) ? exp_q0.size() : exp_q1.size();
                        check_eq($sformatf("frame%0d_expected", g), int'(sz > 0), 1);
                        if (sz == 0) begin
                            skip[g] = 1'b1;
                        end else begin
                            e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            fb = '1;
                            fb[0]   = 1'b0;
                            fb[8:1] = e.w;
`ifdef UART_TX_PARITY_EN
                            fb[9]   = e.par;
`endif
                            fbits[g] = fb;
                            cur_w[g] = e.w;
                            nsamp[g] = (1 + 8 + PB + g + 1) * CPB;
                            s_a[g]   = 0;
                            ferr[g]  = 0;
                            in_fr[g] = 1'b1;
                        end
                    end
                    if (in_fr[g]) begin
                        fb = fbits[g];
                        if (tx_w[g] !== fb[s_a[g] / CPB] || tx_done_w[g] !== 1'b0 ||
                            tx_busy_w[g] !== 1'b1) ferr[g]++;
                        s_a[g]++;
                        if (s_a[g] == nsamp[g]) begin
                            in_fr[g]  = 1'b0;
                            exp_dn[g] = 1'b1;
                        end
                    end else if (tx_done_w[g] !== 1'b0) begin
                        spur++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Directed stimulus
    initial begin : stimulus
        int hs0, hs1, base;
        tx_data_w[0]  = 8'hA5;
        tx_data_w[1]  = 8'h07;
        tx_valid_w[0] = 1'b1;
        tx_valid_w[1] = 1'b1;
        push(0, 8'hA5, 1'b0);
        push(1, 8'h07, 1'b0);

        // Reset held with tx_valid high: idle line, not ready, not busy
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_50M);
            for (int g = 0; g < 2; g++)
                check_eq($sformatf("reset_state%0d", g),
                         int'({tx_w[g], tx_ready_w[g], tx_busy_w[g]}), 3'b100);
        end
        @(posedge clk_50M);
        #1 rst = 1'b0;
        @(negedge clk_50M);
        for (int g = 0; g < 2; g++)
            check_eq($sformatf("ready_after_reset%0d", g), int'(tx_ready_w[g]), 1);
        @(posedge clk_50M);
        #1;
        tx_valid_w[0] = 1'b0;
        tx_valid_w[1] = 1'b0;
        hs0 = cyc;
        @(negedge clk_50M);
        for (int g = 0; g < 2; g++)
            check_eq($sformatf("first_start%0d", g), int'(tx_w[g]), 0);
        wait_done(0, 1);
        wait_done(1, 1);
        check_eq("len_A5", done_cyc[0] - hs0, FL0);
        check_eq("len_07_2stop", done_cyc[1] - hs0, FL1);

        // 0x07 on the even-parity instance
        send(0, 8'h07, 1'b1, hs0);
        wait_done(0, 2);
        check_eq("len_07", done_cyc[0] - hs0, FL0);

        // Back-to-back 0x55 then 0xAA with tx_valid held high
        push(0, 8'h55, 1'b0);
        push(0, 8'hAA, 1'b0);
        @(posedge clk_50M);
        #1;
        tx_data_w[0]  = 8'h55;
        tx_valid_w[0] = 1'b1;
        base = 0;
        @(negedge clk_50M);
        while (!tx_ready_w[0] && base < 500) begin @(negedge clk_50M); base++; end
        @(posedge clk_50M);
        #1 tx_data_w[0] = 8'hAA;
        base = 0;
        @(negedge clk_50M);
        while (!tx_ready_w[0] && base < 500) begin @(negedge clk_50M); base++; end
        check_eq("b2b_second_ready", int'(tx_ready_w[0]), 1);
        @(posedge clk_50M);
        #1 tx_valid_w[0] = 1'b0;
        wait_done(0, 4);
        check_eq("b2b_done_gap", done_cyc[0] - done_prev[0], FL0 + 1);

        // Reset in the middle of data bit 3 of 0xFF
        send(0, 8'hFF, 1'b0, hs0);
        repeat (16) @(posedge clk_50M);
        #1 rst = 1'b1;
        @(negedge clk_50M);
        @(negedge clk_50M);
        check_eq("midframe_reset",
                 int'({tx_w[0], tx_busy_w[0], tx_ready_w[0], tx_done_w[0]}), 4'b1000);
        @(posedge clk_50M);
        #1 rst = 1'b0;
        @(negedge clk_50M);
        check_eq("ready_after_midframe_reset", int'(tx_ready_w[0]), 1);
        repeat (60) @(negedge clk_50M);
        check_eq("no_done_after_abort", done_cnt[0], 4);
        send(0, 8'h3C, 1'b0, hs0);
        wait_done(0, 5);
        check_eq("len_3C", done_cyc[0] - hs0, FL0);

        // Two stop bits; tx_data and tx_valid disturbed while busy
        send(1, 8'h81, 1'b1, hs1);
        repeat (10) @(posedge clk_50M);
        #1;
        tx_data_w[1]  = 8'h7E;
        tx_valid_w[1] = 1'b1;
        @(posedge clk_50M);
        #1 tx_data_w[1] = 8'h00;
        @(posedge clk_50M);
        #1;
        tx_data_w[1]  = 8'hFF;
        tx_valid_w[1] = 1'b0;
        wait_done(1, 2);
        check_eq("len_81_2stop", done_cyc[1] - hs1, FL1);
        repeat (60) @(negedge clk_50M);
        check_eq("no_extra_frame", done_cnt[1], 2);

        check_eq("queue0_drained", exp_q0.size(), 0);
        check_eq("queue1_drained", exp_q1.size(), 0);
        check_eq("spurious_done", spur, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
